display_write_arbiter: RTL



---
 rtl/display_write_arbiter_pkg.sv | 49 ++++
 rtl/display_cycle_serializer.sv | 86 ++++++++
 rtl/display_write_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/display_write_arbiter_pkg.sv
// Shared types, constants and address/character helpers for the display write path.
package display_write_arbiter_pkg;

  typedef enum logic {IDLE, SEQ} DisplayWriteState;
  typedef enum logic {GRANT_CPU, GRANT_REFRESH} DisplayGrant;

  localparam int unsigned REFRESH_NIBBLE_NUM = 8;
  localparam int unsigned COUNT_WIDTH        = 28;

  typedef logic [COUNT_WIDTH-1:0] CountPath;
  typedef logic [1:0]             DisplayRowIndex;
  typedef logic [3:0]             DisplayColumnIndex;
  typedef logic [7:0]             CharPath;

  // Word indices covering the character cells ($8020-$809C)
  localparam logic [6:0] DISPLAY_WORD_FIRST = 7'h08;
  localparam logic [6:0] DISPLAY_WORD_LAST  = 7'h27;

  // Hex nibble to upper-case ASCII
  function automatic CharPath ConvertToASCII(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    return 8'h37 + {4'h0, nibble};
  endfunction

  // Byte address to word index
  function automatic logic [6:0] PICK_IO_ADDR(input logic [15:0] addr);
    logic unused_bits;
    unused_bits = ^{addr[15:9], addr[1:0]};
    return addr[8:2];
  endfunction

  function automatic logic IS_DISPLAY_WORD(input logic [6:0] word);
    return (word >= DISPLAY_WORD_FIRST) && (word <= DISPLAY_WORD_LAST);
  endfunction

  function automatic DisplayRowIndex GET_DISPLAY_ROW_ADDR(input logic [6:0] word);
    logic unused_bits;
    unused_bits = ^{word[6:5], word[2:0]};
    return word[4:3];
  endfunction

  // Words fill the right half of a row from the right edge inwards
  function automatic DisplayColumnIndex GET_DISPLAY_COLOMN_ADDR(input logic [6:0] word);
    logic unused_bits;
    unused_bits = ^word[6:3];
    return {1'b1, 3'b111 - word[2:0]};
  endfunction

endpackage

// File: rtl/display_cycle_serializer.sv
// Periodic refresh: timer, one-deep pending flag, cycle snapshot and hex serializer.
module display_cycle_serializer
  import display_write_arbiter_pkg::*;
#(
  parameter CountPath    REFRESH_PERIOD = 28'h3000,
  parameter int unsigned CYCLE_ROW      = 1,
  parameter int unsigned CYCLE_COL      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cycle_enable,
  input  logic [31:0]       i_cycle,
  input  logic              i_grant,
  output logic              o_req,
  output DisplayRowIndex    o_row,
  output DisplayColumnIndex o_col,
  output CharPath           o_char,
  output logic              o_busy
);

  localparam CountPath          RELOAD      = REFRESH_PERIOD - 28'd1;
  localparam DisplayRowIndex    ROW         = DisplayRowIndex'(CYCLE_ROW);
  localparam DisplayColumnIndex COL0        = DisplayColumnIndex'(CYCLE_COL);
  localparam logic [2:0]        LAST_NIBBLE = 3'(REFRESH_NIBBLE_NUM - 1);

  DisplayWriteState r_state, w_state_next;
  CountPath         r_timer, w_timer_next;
  logic             r_pending, w_pending_next;
  logic [31:0]      r_snap, w_snap_next;
  logic [2:0]       r_nibble, w_nibble_next;
  logic             r_busy;
  logic             w_expire, w_last_step, w_start;
  logic [3:0]       w_nibble_val;

  // Timer countdown, pending flag and sequence next-state
  always_comb begin
    w_expire     = i_cycle_enable && (r_timer == '0);
    w_timer_next = r_timer;
    if (i_cycle_enable) w_timer_next = w_expire ? RELOAD : r_timer - 28'd1;

    w_last_step   = (r_state == SEQ) && i_grant && (r_nibble == LAST_NIBBLE);
    // A queued request starts from IDLE, or chains straight on after the last nibble
    w_start       = r_pending && ((r_state == IDLE) || w_last_step);
    w_state_next  = r_state;
    w_snap_next   = r_snap;
    w_nibble_next = r_nibble;
    if (w_start) begin
      w_state_next  = SEQ;
      w_snap_next   = i_cycle;
      w_nibble_next = '0;
    end else if ((r_state == SEQ) && i_grant) begin
      w_nibble_next = r_nibble + 3'd1;
      if (r_nibble == LAST_NIBBLE) w_state_next = IDLE;
    end
    // An expiry while already pending is absorbed
    w_pending_next = w_expire | (r_pending & ~w_start);
  end

  // State registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_timer   <= RELOAD;
      r_pending <= 1'b0;
      r_snap    <= '0;
      r_nibble  <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_pending <= w_pending_next;
      r_snap    <= w_snap_next;
      r_nibble  <= w_nibble_next;
      r_busy    <= w_pending_next | (w_state_next == SEQ);
    end
  end

  // Nibble k sits at bits [31-4k -: 4]; 28-4k == 4*(~k) for a 3-bit k
  assign w_nibble_val = 4'(r_snap >> {~r_nibble, 2'b00});
  assign o_req        = (r_state == SEQ);
  assign o_row        = ROW;
  assign o_col        = COL0 + DisplayColumnIndex'({1'b0, r_nibble});
  assign o_char       = ConvertToASCII(w_nibble_val);
  assign o_busy       = r_busy;

endmodule

// File: rtl/display_write_arbiter.sv
// Shares the display buffer write port between CPU stores and the cycle-count refresh.
module display_write_arbiter
  import display_write_arbiter_pkg::*;
#(
  parameter CountPath    REFRESH_PERIOD = 28'h3000,
  parameter int unsigned CYCLE_ROW      = 1,
  parameter int unsigned CYCLE_COL      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [31:0] i_cpu_data,
  output logic        o_cpu_ready,
  input  logic        i_cycle_enable,
  input  logic [31:0] i_cycle,
  output logic        o_disp_we,
  output logic [1:0]  o_disp_row,
  output logic [3:0]  o_disp_col,
  output logic [7:0]  o_disp_char,
  output logic        o_busy
);

  logic              r_buf_valid;
  DisplayRowIndex    r_buf_row;
  DisplayColumnIndex r_buf_col;
  CharPath           r_buf_char;
  DisplayGrant       r_last_grant;
  logic              r_disp_we;
  DisplayRowIndex    r_disp_row;
  DisplayColumnIndex r_disp_col;
  CharPath           r_disp_char;

  logic [6:0]        w_word;
  logic              w_accept;
  logic              w_ref_req, w_grant_cpu, w_grant_ref;
  DisplayRowIndex    w_ref_row;
  DisplayColumnIndex w_ref_col;
  CharPath           w_ref_char;
  logic              w_unused_data;

  assign w_unused_data = ^i_cpu_data[31:8];
  assign w_word        = PICK_IO_ADDR(i_cpu_addr);
  assign o_cpu_ready   = ~r_buf_valid;
  // Out-of-range stores are accepted by the handshake but never occupy the buffer
  assign w_accept      = i_cpu_we && !r_buf_valid && IS_DISPLAY_WORD(w_word);

  display_cycle_serializer #(
    .REFRESH_PERIOD(REFRESH_PERIOD),
    .CYCLE_ROW     (CYCLE_ROW),
    .CYCLE_COL     (CYCLE_COL)
  ) u_serializer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_cycle_enable(i_cycle_enable),
    .i_cycle       (i_cycle),
    .i_grant       (w_grant_ref),
    .o_req         (w_ref_req),
    .o_row         (w_ref_row),
    .o_col         (w_ref_col),
    .o_char        (w_ref_char),
    .o_busy        (o_busy)
  );

  // Alternating priority: on contention the side not granted last wins
  always_comb begin
    w_grant_cpu = r_buf_valid && (!w_ref_req || (r_last_grant == GRANT_REFRESH));
    w_grant_ref = w_ref_req && !w_grant_cpu;
  end

  // One-entry CPU store buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf_valid <= 1'b0;
      r_buf_row   <= '0;
      r_buf_col   <= '0;
      r_buf_char  <= '0;
    end else if (w_accept) begin
      r_buf_valid <= 1'b1;
      r_buf_row   <= GET_DISPLAY_ROW_ADDR(w_word);
      r_buf_col   <= GET_DISPLAY_COLOMN_ADDR(w_word);
      r_buf_char  <= i_cpu_data[7:0];
    end else if (w_grant_cpu) begin
      r_buf_valid <= 1'b0;
    end
  end

  // Registered write port and grant history
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_disp_we    <= 1'b0;
      r_disp_row   <= '0;
      r_disp_col   <= '0;
      r_disp_char  <= '0;
      r_last_grant <= GRANT_REFRESH;
    end else begin
      r_disp_we <= w_grant_cpu | w_grant_ref;
      if (w_grant_cpu) begin
        r_disp_row   <= r_buf_row;
        r_disp_col   <= r_buf_col;
        r_disp_char  <= r_buf_char;
        r_last_grant <= GRANT_CPU;
      end else if (w_grant_ref) begin
        r_disp_row   <= w_ref_row;
        r_disp_col   <= w_ref_col;
        r_disp_char  <= w_ref_char;
        r_last_grant <= GRANT_REFRESH;
      end
    end
  end

  assign o_disp_we   = r_disp_we;
  assign o_disp_row  = r_disp_row;
  assign o_disp_col  = r_disp_col;
  assign o_disp_char = r_disp_char;

endmodule
